// File: rtl/ram_lsu_pkg.sv
// Shared types and helpers for the ram_lsu data-memory block.
// Helpers work on the widest supported word (64 bits); callers truncate to DATA_WIDTH.
package ram_lsu_pkg;

    localparam int unsigned MAX_DW = 64;
    localparam int unsigned MAX_NB = MAX_DW / 8;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_e;

    // Byte lanes touched by an access of 2^size bytes starting at lane off.
    function automatic logic [MAX_NB-1:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
        logic [MAX_NB-1:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

    // Offset not a multiple of the access size.
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return |off[1:0];
            default: return |off;
        endcase
    endfunction

    // Select the addressed sub-word and sign- or zero-extend it.
    function automatic logic [MAX_DW-1:0] load_extend(input logic [MAX_DW-1:0] word,
                                                      input logic [2:0]        off,
                                                      input logic [1:0]        size,
                                                      input logic              is_unsigned);
        logic [MAX_DW-1:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            SZ_B:    return is_unsigned ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            SZ_H:    return is_unsigned ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            SZ_W:    return is_unsigned ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: return sh;
        endcase
    endfunction

endpackage

// File: rtl/ram_lane.sv
// One byte-wide lane of the data memory: single-port array with a registered read.
module ram_lane #(
    parameter int unsigned DEPTH = 4096,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata
);

    logic [7:0] mem [DEPTH];

    // Array contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 8'd0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/ram_lsu.sv
// Data memory with load/store handling: byte-enable stores, extended loads one cycle
// later, misalignment/size error reporting and an optional post-reset zero-fill sweep.
module ram_lsu
    import ram_lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned DEPTH          = 4096,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  init_done
);

    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam state_e      ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       clr_cnt_q, clr_cnt_d;

    logic [OFF_W-1:0]       off_c;
    logic [IDX_W-1:0]       idx_c;
    logic                   accept_c;
    logic                   err_c;
    logic [DATA_WIDTH-1:0]  wdata_sh_c;

    logic [NB-1:0]          lane_we;
    logic                   ram_re;
    logic [IDX_W-1:0]       ram_idx;
    logic [DATA_WIDTH-1:0]  ram_wdata;
    logic [DATA_WIDTH-1:0]  rd_word;

    logic                   zero_q;
    logic [OFF_W-1:0]       off_q;
    logic [1:0]             size_q;
    logic                   uns_q;

    logic                   unused_addr;

    assign off_c       = req_addr[OFF_W-1:0];
    assign idx_c       = req_addr[OFF_W+IDX_W-1:OFF_W];
    assign unused_addr = ^req_addr[ADDR_WIDTH-1:OFF_W+IDX_W];

    assign req_ready  = (state_q == ST_RUN);
    assign init_done  = (state_q == ST_RUN);
    assign accept_c   = req_valid & req_ready;
    assign err_c      = (req_size > 2'(OFF_W)) | misaligned(req_size, 3'(off_c));
    assign wdata_sh_c = req_wdata << {off_c, 3'b000};

    // State register and sweep counter.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_RESET;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next state plus RAM port steering: the sweep owns the array until RUN.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        lane_we   = '0;
        ram_re    = 1'b0;
        ram_idx   = idx_c;
        ram_wdata = wdata_sh_c;
        case (state_q)
            ST_CLEAR: begin
                lane_we   = '1;
                ram_idx   = clr_cnt_q;
                ram_wdata = '0;
                clr_cnt_d = clr_cnt_q + IDX_W'(1);
                if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (accept_c && !err_c) begin
                    if (req_we) begin
                        lane_we = NB'(lane_mask(req_size, 3'(off_c)));
                    end else begin
                        ram_re = 1'b1;
                    end
                end
            end
        endcase
    end

    for (genvar i = 0; i < NB; i++) begin : g_lane
        ram_lane #(
            .DEPTH (DEPTH)
        ) u_lane (
            .clk   (sys_clk),
            .rst_n (sys_rst_n),
            .we    (lane_we[i]),
            .re    (ram_re),
            .idx   (ram_idx),
            .wdata (ram_wdata[8*i +: 8]),
            .rdata (rd_word[8*i +: 8])
        );
    end

    // Response side: everything updates only on accept so idle cycles hold the last response.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            zero_q    <= 1'b1;
            off_q     <= '0;
            size_q    <= SZ_B;
            uns_q     <= 1'b0;
        end else begin
            rsp_valid <= accept_c;
            if (accept_c) begin
                rsp_err <= err_c;
                zero_q  <= err_c | req_we;
                off_q   <= off_c;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
            end
        end
    end

    // Extension runs off the lane read registers and the captured access attributes.
    assign rsp_rdata = zero_q ? '0
                     : DATA_WIDTH'(load_extend(64'(rd_word), 3'(off_q), size_q, uns_q));

endmodule

// File: tb/tb_ram_lsu.sv
// Scoreboard bench for ram_lsu (32-bit words, 16-word depth, zero-fill enabled).
module tb_ram_lsu;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 32;

    logic          sys_clk;
    logic          sys_rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          init_done;

    typedef struct {
        string         tag;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk;
    int   n_fail;
    int   n_issued;
    int   n_rsp;
    int   run_len;
    int   max_run;

    ram_lsu #(
        .DATA_WIDTH     (DW),
        .DEPTH          (DEPTH),
        .ADDR_WIDTH     (AW),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .init_done    (init_done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every response pulse.
    always @(posedge sys_clk) begin
        exp_t e;
        #1;
        if (rsp_valid === 1'b1) begin
            n_rsp++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (exp_q.size() == 0) begin
                check("rsp_valid_spurious", rsp_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check({e.tag, "_rdata"}, rsp_rdata, e.rdata);
                check({e.tag, "_err"}, rsp_err, e.err);
            end
        end else begin
            run_len = 0;
        end
    end

    // Drive one request at a negedge; returns at the following negedge.
    task automatic issue(input string tag, input logic we, input logic [1:0] size,
                         input logic uns, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [DW-1:0] exp_rdata, input logic exp_err);
        exp_t e;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        e.tag   = tag;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        exp_q.push_back(e);
        n_issued++;
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge sys_clk);
    endtask

    // Count edges from reset release until init_done, with req_ready held low meanwhile.
    task automatic wait_init(input string tag);
        int   n;
        logic early_ready;
        n = 0;
        early_ready = 1'b0;
        while (init_done !== 1'b1 && n < 100) begin
            @(posedge sys_clk);
            #1;
            n++;
            if (init_done !== 1'b1 && req_ready !== 1'b0) early_ready = 1'b1;
        end
        check({tag, "_cycles"}, n, DEPTH);
        check({tag, "_ready_low"}, early_ready, 1'b0);
        check({tag, "_ready_high"}, req_ready, 1'b1);
        @(negedge sys_clk);
    endtask

    initial begin
        int waited;
        n_chk = 0; n_fail = 0; n_issued = 0; n_rsp = 0; run_len = 0; max_run = 0;
        sys_rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge sys_clk);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_init_done", init_done, 1'b0);
        check("rst_req_ready", req_ready, 1'b0);
        sys_rst_n = 1'b1;
        wait_init("init");

        issue("lw_3c_cleared", 1'b0, 2'd2, 1'b0, 32'h3C, 32'h0, 32'h0000_0000, 1'b0);
        issue("sw_10",         1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
        issue("lb_13",         1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'hFFFF_FFDE, 1'b0);
        issue("lbu_13",        1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h0000_00DE, 1'b0);
        issue("lh_10",         1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 32'hFFFF_BEEF, 1'b0);
        issue("lhu_12",        1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'h0000_DEAD, 1'b0);
        issue("sb_11",         1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFF_FF5A, 32'h0, 1'b0);
        issue("lw_10_merged",  1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEAD_5AEF, 1'b0);
        idle(2);

        issue("sw_20",         1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFE_F00D, 32'h0, 1'b0);
        issue("sh_21_misal",   1'b1, 2'd1, 1'b0, 32'h21, 32'h0000_1111, 32'h0, 1'b1);
        issue("sw_22_misal",   1'b1, 2'd2, 1'b0, 32'h22, 32'h2222_2222, 32'h0, 1'b1);
        issue("sd_20_size",    1'b1, 2'd3, 1'b0, 32'h20, 32'h3333_3333, 32'h0, 1'b1);
        issue("ld_20_size",    1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1);
        issue("lw_20_intact",  1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'hCAFE_F00D, 1'b0);
        idle(2);

        issue("sw_40",         1'b1, 2'd2, 1'b0, 32'h40, 32'h1234_5678, 32'h0, 1'b0);
        issue("lw_40_b2b",     1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h1234_5678, 1'b0);
        issue("lw_00_wrap",    1'b0, 2'd2, 1'b0, 32'h00, 32'h0, 32'h1234_5678, 1'b0);
        idle(3);

        max_run = 0;
        issue("s_sw_30",  1'b1, 2'd2, 1'b0, 32'h30, 32'h1111_1111, 32'h0, 1'b0);
        issue("s_sw_34",  1'b1, 2'd2, 1'b0, 32'h34, 32'h2222_2222, 32'h0, 1'b0);
        issue("s_lw_30",  1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 32'h1111_1111, 1'b0);
        issue("s_lw_34",  1'b0, 2'd2, 1'b0, 32'h34, 32'h0, 32'h2222_2222, 1'b0);
        issue("s_sb_35",  1'b1, 2'd0, 1'b0, 32'h35, 32'h0000_0077, 32'h0, 1'b0);
        issue("s_lbu_35", 1'b0, 2'd0, 1'b1, 32'h35, 32'h0, 32'h0000_0077, 1'b0);
        issue("s_lh_34",  1'b0, 2'd1, 1'b0, 32'h34, 32'h0, 32'h0000_7722, 1'b0);
        issue("s_lb_30",  1'b0, 2'd0, 1'b0, 32'h30, 32'h0, 32'h0000_0011, 1'b0);
        idle(3);
        check("stream_run", max_run, 8);
        check("hold_rdata", rsp_rdata, 32'h0000_0011);

        // Reset lands on a load's accept edge: that load must never respond.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
        #2 sys_rst_n = 1'b0;
        @(posedge sys_clk);
        #1;
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        check("midrst_rsp_rdata", rsp_rdata, 32'h0);
        check("midrst_rsp_err", rsp_err, 1'b0);
        check("midrst_init_done", init_done, 1'b0);
        @(negedge sys_clk);
        req_valid = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        wait_init("reinit");
        issue("lw_10_recleared", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
        idle(2);

        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(negedge sys_clk);
            waited++;
        end
        check("scoreboard_empty", exp_q.size(), 0);
        check("rsp_count", n_rsp, n_issued);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_lsu.md
Name: ram_lsu

Overview:
Parametrised data-memory block for the 3-stage core: a byte-lane RAM plus load/store handling. Accepts one load or store per cycle via a valid/ready request channel and performs byte-enable writes with sub-word alignment. Returns sign- or zero-extended load data one cycle later. Adds an optional post-reset zero-fill sweep, misalignment/size error reporting, and generalised width/depth.

Parameters:
DATA_WIDTH, 32, word width in bits; multiple of 8, power of two (32 or 64); NB = DATA_WIDTH/8 lanes
DEPTH, 4096, words per lane; power of two; IDX_W = log2(DEPTH)
ADDR_WIDTH, 32, byte address width
CLEAR_ON_RESET, 1, 1 = zero-fill all words after reset before accepting requests

Ports:
sys_clk  in  1  clock, all state on rising edge
sys_rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_size  in  2  log2 of access bytes: 0 byte, 1 half, 2 word, 3 dword (legal only if NB = 8)
req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, right-aligned (LSBs)
rsp_valid  out  1  response pulse, exactly one per accepted request
rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
rsp_err  out  1  accepted request was misaligned or had an illegal size
init_done  out  1  high once zero-fill has finished (constant 1 when CLEAR_ON_RESET = 0)

Behaviour:
- Reset (async): rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, clear counter = 0. State = CLEAR if CLEAR_ON_RESET, else RUN. Memory contents are not reset.
- State CLEAR: the block writes 0 to all NB lanes at word clr_cnt and increments clr_cnt each cycle. After writing DEPTH-1, it moves to RUN. req_ready = 0 and init_done = 0 throughout. CLEAR lasts exactly DEPTH cycles.
- State RUN: req_ready = 1 and init_done = 1. RUN is terminal until reset.
- A request is accepted when req_valid && req_ready.
- Addressing: off = req_addr[log2(NB)-1:0]; idx = req_addr[log2(NB)+IDX_W-1 : log2(NB)]. Upper address bits are ignored, so addresses wrap modulo DEPTH*NB.
- Error check: error if req_size > log2(NB), or off is not a multiple of 2^req_size. On error, memory is not written, rsp_err = 1, and rsp_rdata = 0.
- Store (no error):
  - lane mask = ((1 << 2^size) - 1) << off.
  - Data = req_wdata replicated/shifted left by off*8.
  - Written at the accept edge; lanes outside the mask are unchanged.
  - rsp_valid = 1 next cycle with rsp_rdata = 0 and rsp_err = 0.
- Load (no error):
  - Synchronous read of word idx at the accept edge.
  - The block registers off, size, and unsigned alongside the read.
  - Next cycle, rsp_rdata = word >> (off*8), truncated to 2^size bytes, then sign- or zero-extended to DATA_WIDTH.
  - Latency is 1 cycle; throughput is 1 per cycle.
- Back-to-back: a store at cycle N followed by a load to the same word at N+1 returns the stored data. No bypass is needed because the array is updated at edge N. There are no simultaneous read and write, since there is a single request port.
- rsp_valid is a single-cycle pulse with no backpressure; the consumer must take it. When idle, rsp_valid = 0 and rsp_rdata/rsp_err hold their last values.
- Reset mid-CLEAR or mid-access: state returns to its reset value and any in-flight response is dropped (rsp_valid = 0). If CLEAR_ON_RESET = 1, the sweep restarts from 0.

Decomposition:
- Package ram_lsu_pkg:
  - size encodings SZ_B = 0, SZ_H = 1, SZ_W = 2, SZ_D = 3
  - state enum {ST_CLEAR, ST_RUN}
  - function lane_mask(size, off)
  - function load_extend(word, off, size, unsigned)
- Sub-module ram_lane: one 8-bit x DEPTH synchronous RAM with write enable, write/read index, and registered read. Instantiated NB times via generate. The top level holds the FSM, clear counter, error logic and response register.

Test Plan:
- CLEAR_ON_RESET = 1, DEPTH = 16: release reset → init_done rises after exactly 16 cycles, req_ready = 0 until then; load addr 0x3C then returns 0x00000000.
- sw 0xDEADBEEF @0x10, then lb @0x13 → 0xFFFFFFDE; lbu @0x13 → 0x000000DE; lh @0x10 → 0xFFFFBEEF; lhu @0x12 → 0x0000DEAD.
- sb 0x5A @0x11 after the previous sw, then lw @0x10 → 0xDEAD5AEF. Other lanes are untouched.
- Misaligned sh @0x21 and sw @0x22, and size 3 with DATA_WIDTH = 32 → rsp_err = 1, rsp_rdata = 0. A following lw @0x20 shows memory unchanged.
- Back-to-back: sw 0x12345678 @0x40 at cycle N, lw @0x40 at N+1 → rsp_valid at N+2 with 0x12345678. One rsp_valid per request, with no gaps in a stream of 8 requests.
- Assert sys_rst_n low during a load's accept cycle → no rsp_valid afterwards, outputs 0, and the CLEAR sweep restarts.
